// File: rtl/mp3_granule_sequencer.sv
// Granule scheduler for the HUFF and SYN engines: ping-pong over two granule buffers,
// SYN paced by PCM RAM space, with a per-engine watchdog that aborts a hung engine.
module mp3_granule_sequencer #(
    parameter int unsigned TIMEOUT_W  = 20,
    parameter bit          TIMEOUT_EN = 1'b1
) (
    input  logic CLK_I,
    input  logic global_rst_n,
    input  logic module_en,
    input  logic frame_valid,
    input  logic frame_stereo,
    output logic frame_ack,
    output logic frame_done,
    output logic huff_start,
    output logic huff_buf_sel,
    output logic huff_gr,
    output logic huff_ch,
    input  logic huff_done,
    output logic syn_start,
    output logic syn_buf_sel,
    output logic syn_gr,
    output logic syn_ch,
    input  logic syn_done,
    input  logic pcm_slot_free,
    output logic busy,
    output logic err_timeout
);
    typedef enum logic [1:0] {H_IDLE, H_ISSUE, H_RUN} huff_state_e;
    typedef enum logic       {S_IDLE, S_RUN}          syn_state_e;

    // The counter holds the number of completed RUN cycles, so it trips as it turns all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    huff_state_e h_state_q, h_state_d;
    syn_state_e  s_state_q, s_state_d;
    logic [1:0]      buf_full_q, buf_full_d;
    logic [1:0][2:0] tag_q, tag_d;
    logic hp_q, hp_d, sp_q, sp_d;
    logic stereo_q, stereo_d;
    logic [1:0] unit_q, unit_d;
    logic [TIMEOUT_W-1:0] h_wd_q, h_wd_d, s_wd_q, s_wd_d;
    logic err_q, err_d;
    logic frame_ack_q, frame_ack_d, frame_done_q, frame_done_d;
    logic huff_start_q, huff_start_d, huff_sel_q, huff_sel_d;
    logic huff_gr_q, huff_gr_d, huff_ch_q, huff_ch_d;
    logic syn_start_q, syn_start_d, syn_sel_q, syn_sel_d;
    logic syn_gr_q, syn_gr_d, syn_ch_q, syn_ch_d;
    logic busy_q, busy_d;

    logic cur_gr, cur_ch, cur_last;
    logic h_done_ok, s_done_ok, h_to, s_to;

    // Unit order: stereo walks (g,c) = 00,01,10,11; mono walks 00,10.
    assign cur_gr   = stereo_q ? unit_q[1] : unit_q[0];
    assign cur_ch   = stereo_q & unit_q[0];
    assign cur_last = stereo_q ? (unit_q == 2'd3) : (unit_q == 2'd1);

    assign h_done_ok = (h_state_q == H_RUN) && huff_done && !huff_start_q;
    assign s_done_ok = (s_state_q == S_RUN) && syn_done && !syn_start_q;
    assign h_to = TIMEOUT_EN && (h_state_q == H_RUN) && (h_wd_q == WD_LAST) && !h_done_ok;
    assign s_to = TIMEOUT_EN && (s_state_q == S_RUN) && (s_wd_q == WD_LAST) && !s_done_ok;

    always_comb begin
        h_state_d    = h_state_q;
        s_state_d    = s_state_q;
        buf_full_d   = buf_full_q;
        tag_d        = tag_q;
        hp_d         = hp_q;
        sp_d         = sp_q;
        stereo_d     = stereo_q;
        unit_d       = unit_q;
        h_wd_d       = h_wd_q;
        s_wd_d       = s_wd_q;
        err_d        = err_q;
        frame_ack_d  = 1'b0;
        frame_done_d = 1'b0;
        huff_start_d = 1'b0;
        huff_sel_d   = huff_sel_q;
        huff_gr_d    = huff_gr_q;
        huff_ch_d    = huff_ch_q;
        syn_start_d  = 1'b0;
        syn_sel_d    = syn_sel_q;
        syn_gr_d     = syn_gr_q;
        syn_ch_d     = syn_ch_q;

        unique case (h_state_q)
            H_IDLE: if (frame_valid && module_en && !err_q) begin
                h_state_d   = H_ISSUE;
                frame_ack_d = 1'b1;
                stereo_d    = frame_stereo;
                unit_d      = 2'd0;
            end
            H_ISSUE: if (!buf_full_q[hp_q] && module_en && !err_q) begin
                h_state_d    = H_RUN;
                huff_start_d = 1'b1;
                huff_sel_d   = hp_q;
                huff_gr_d    = cur_gr;
                huff_ch_d    = cur_ch;
                h_wd_d       = '0;
            end
            H_RUN: begin
                h_wd_d = h_wd_q + WD_ONE;
                if (h_done_ok) begin
                    buf_full_d[hp_q] = 1'b1;
                    tag_d[hp_q]      = {cur_gr, cur_ch, cur_last};
                    hp_d             = ~hp_q;
                    unit_d           = unit_q + 2'd1;
                    h_state_d        = cur_last ? H_IDLE : H_ISSUE;
                end
            end
            default: h_state_d = H_IDLE;
        endcase

        // SYN clears a different buffer than HUFF sets, so both updates can land together.
        unique case (s_state_q)
            S_IDLE: if (buf_full_q[sp_q] && pcm_slot_free && module_en && !err_q) begin
                s_state_d   = S_RUN;
                syn_start_d = 1'b1;
                syn_sel_d   = sp_q;
                syn_gr_d    = tag_q[sp_q][2];
                syn_ch_d    = tag_q[sp_q][1];
                s_wd_d      = '0;
            end
            S_RUN: begin
                s_wd_d = s_wd_q + WD_ONE;
                if (s_done_ok) begin
                    buf_full_d[sp_q] = 1'b0;
                    sp_d             = ~sp_q;
                    s_state_d        = S_IDLE;
                    frame_done_d     = tag_q[sp_q][0];
                end
            end
            default: s_state_d = S_IDLE;
        endcase

        if (h_to || s_to) begin
            h_state_d    = H_IDLE;
            s_state_d    = S_IDLE;
            buf_full_d   = 2'b00;
            hp_d         = 1'b0;
            sp_d         = 1'b0;
            h_wd_d       = '0;
            s_wd_d       = '0;
            err_d        = 1'b1;
            frame_done_d = 1'b0;
        end

        busy_d = (h_state_d != H_IDLE) | (s_state_d != S_IDLE) | (|buf_full_d);
    end

    always_ff @(posedge CLK_I) begin
        if (!global_rst_n) begin
            h_state_q    <= H_IDLE;
            s_state_q    <= S_IDLE;
            buf_full_q   <= 2'b00;
            tag_q        <= '0;
            hp_q         <= 1'b0;
            sp_q         <= 1'b0;
            stereo_q     <= 1'b0;
            unit_q       <= 2'd0;
            h_wd_q       <= '0;
            s_wd_q       <= '0;
            err_q        <= 1'b0;
            frame_ack_q  <= 1'b0;
            frame_done_q <= 1'b0;
            huff_start_q <= 1'b0;
            huff_sel_q   <= 1'b0;
            huff_gr_q    <= 1'b0;
            huff_ch_q    <= 1'b0;
            syn_start_q  <= 1'b0;
            syn_sel_q    <= 1'b0;
            syn_gr_q     <= 1'b0;
            syn_ch_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            h_state_q    <= h_state_d;
            s_state_q    <= s_state_d;
            buf_full_q   <= buf_full_d;
            tag_q        <= tag_d;
            hp_q         <= hp_d;
            sp_q         <= sp_d;
            stereo_q     <= stereo_d;
            unit_q       <= unit_d;
            h_wd_q       <= h_wd_d;
            s_wd_q       <= s_wd_d;
            err_q        <= err_d;
            frame_ack_q  <= frame_ack_d;
            frame_done_q <= frame_done_d;
            huff_start_q <= huff_start_d;
            huff_sel_q   <= huff_sel_d;
            huff_gr_q    <= huff_gr_d;
            huff_ch_q    <= huff_ch_d;
            syn_start_q  <= syn_start_d;
            syn_sel_q    <= syn_sel_d;
            syn_gr_q     <= syn_gr_d;
            syn_ch_q     <= syn_ch_d;
            busy_q       <= busy_d;
        end
    end

    assign frame_ack    = frame_ack_q;
    assign frame_done   = frame_done_q;
    assign huff_start   = huff_start_q;
    assign huff_buf_sel = huff_sel_q;
    assign huff_gr      = huff_gr_q;
    assign huff_ch      = huff_ch_q;
    assign syn_start    = syn_start_q;
    assign syn_buf_sel  = syn_sel_q;
    assign syn_gr       = syn_gr_q;
    assign syn_ch       = syn_ch_q;
    assign busy         = busy_q;
    assign err_timeout  = err_q;

endmodule
